// File: rtl/mem_responder_if.sv
// Request/response channel between the core's memory port and mem_responder.
interface mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_wstrb, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_wstrb, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/mem_responder.sv
// Single-outstanding word memory responder with a fixed wait-state count.
// Optional MEMRESP_ALIGN_CHECK_EN: misaligned byte addresses are errored.
module mem_responder #(
    parameter int unsigned DEPTH   = 1024,
    parameter int unsigned LATENCY = 2
) (
    input  logic            clk,
    input  logic            reset,
    mem_responder_if.slave  bus,
    output logic            busy
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = 4;
    localparam logic [CW-1:0] LAT = CW'(LATENCY);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          enter_resp_c;

    logic          wr_q;
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;
    logic [3:0]    wstrb_q;

    logic          req_ready_q, req_ready_d;
    logic          busy_q, busy_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [31:0]   rsp_rdata_q, rsp_rdata_d;
    logic          rsp_err_q, rsp_err_d;

    logic [31:0]   mem_q [DEPTH];
    logic          mem_we_c;
    logic [31:0]   wmerge_c;

    logic          cur_write_c;
    logic [31:0]   cur_addr_c;
    logic [31:0]   cur_wdata_c;
    logic [3:0]    cur_wstrb_c;
    logic [AW-1:0] word_c;
    logic          misalign_c;
    logic          err_c;

    // With zero wait states RESP is entered on the accepting edge, before the latches load.
    assign cur_write_c = (state_q == S_IDLE) ? bus.req_write : wr_q;
    assign cur_addr_c  = (state_q == S_IDLE) ? bus.req_addr  : addr_q;
    assign cur_wdata_c = (state_q == S_IDLE) ? bus.req_wdata : wdata_q;
    assign cur_wstrb_c = (state_q == S_IDLE) ? bus.req_wstrb : wstrb_q;

    assign word_c = cur_addr_c[AW+1:2];

`ifdef MEMRESP_ALIGN_CHECK_EN
    assign misalign_c = |cur_addr_c[1:0];
`else
    logic unused_addr_lsb_c;
    assign unused_addr_lsb_c = ^cur_addr_c[1:0];
    assign misalign_c        = 1'b0;
`endif

    assign err_c = (|cur_addr_c[31:AW+2]) | misalign_c;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        enter_resp_c = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    if (LATENCY == 0) begin
                        state_d      = S_RESP;
                        enter_resp_c = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = LAT;
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d      = S_RESP;
                    enter_resp_c = 1'b1;
                end
            end
            S_RESP: begin
                if (bus.rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output and commit logic
    always_comb begin
        req_ready_d = (state_d == S_IDLE);
        busy_d      = (state_d != S_IDLE);
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        mem_we_c    = 1'b0;
        if (enter_resp_c) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = err_c;
            rsp_rdata_d = (cur_write_c || err_c) ? 32'h0 : mem_q[word_c];
            mem_we_c    = cur_write_c && !err_c;
        end else if (state_q == S_RESP && bus.rsp_ready) begin
            rsp_valid_d = 1'b0;
            rsp_rdata_d = 32'h0;
            rsp_err_d   = 1'b0;
        end
    end

    always_comb begin
        wmerge_c = mem_q[word_c];
        for (int i = 0; i < 4; i++) begin
            if (cur_wstrb_c[i]) wmerge_c[8*i +: 8] = cur_wdata_c[8*i +: 8];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
        end else begin
            req_ready_q <= req_ready_d;
            busy_q      <= busy_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Request latch, loaded only while idle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_q    <= 1'b0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            wstrb_q <= 4'h0;
        end else if (state_q == S_IDLE && bus.req_valid) begin
            wr_q    <= bus.req_write;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
            wstrb_q <= bus.req_wstrb;
        end
    end

    // Storage array; contents survive reset
    always_ff @(posedge clk) begin
        if (mem_we_c) mem_q[word_c] <= wmerge_c;
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: one LATENCY=2 instance (index 0) and one LATENCY=0 instance (index 1),
// checked against a word-level memory model and per-transaction expected responses.
module tb_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst    [2];
    logic        rv     [2];
    logic        rw     [2];
    logic [31:0] ra     [2];
    logic [31:0] rd     [2];
    logic [3:0]  rs     [2];
    logic        rr     [2];
    logic        qready [2];
    logic        pvalid [2];
    logic [31:0] prdata [2];
    logic        perr   [2];
    logic        pbusy  [2];
    logic        busy_l2, busy_l0;

    mem_responder_if bus_l2 ();
    mem_responder_if bus_l0 ();

    assign bus_l2.req_valid = rv[0];
    assign bus_l2.req_write = rw[0];
    assign bus_l2.req_addr  = ra[0];
    assign bus_l2.req_wdata = rd[0];
    assign bus_l2.req_wstrb = rs[0];
    assign bus_l2.rsp_ready = rr[0];
    assign qready[0] = bus_l2.req_ready;
    assign pvalid[0] = bus_l2.rsp_valid;
    assign prdata[0] = bus_l2.rsp_rdata;
    assign perr[0]   = bus_l2.rsp_err;
    assign pbusy[0]  = busy_l2;

    assign bus_l0.req_valid = rv[1];
    assign bus_l0.req_write = rw[1];
    assign bus_l0.req_addr  = ra[1];
    assign bus_l0.req_wdata = rd[1];
    assign bus_l0.req_wstrb = rs[1];
    assign bus_l0.rsp_ready = rr[1];
    assign qready[1] = bus_l0.req_ready;
    assign pvalid[1] = bus_l0.rsp_valid;
    assign prdata[1] = bus_l0.rsp_rdata;
    assign perr[1]   = bus_l0.rsp_err;
    assign pbusy[1]  = busy_l0;

    mem_responder #(.DEPTH(1024), .LATENCY(2)) u_l2 (
        .clk(clk), .reset(rst[0]), .bus(bus_l2.slave), .busy(busy_l2)
    );
    mem_responder #(.DEPTH(1024), .LATENCY(0)) u_l0 (
        .clk(clk), .reset(rst[1]), .bus(bus_l0.slave), .busy(busy_l0)
    );

    int checks   = 0;
    int failures = 0;

    logic [31:0] mdl [int unsigned];
    logic        exp_pend  [2];
    logic        exp_err   [2];
    logic        exp_known [2];
    logic [31:0] exp_rdata [2];
    time         acc_time  [2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare live response outputs against the outstanding transaction's expectation
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rst[d] === 1'b1 && pvalid[d] === 1'b1) begin
                chk("rsp_valid_expected", 32'(exp_pend[d]), 32'd1);
                chk("req_ready_in_resp", 32'(qready[d]), 32'd0);
                chk("busy_in_resp", 32'(pbusy[d]), 32'd1);
                chk("rsp_err", 32'(perr[d]), 32'(exp_err[d]));
                if (exp_known[d]) chk("rsp_rdata", prdata[d], exp_rdata[d]);
            end
        end
    end

    task automatic do_req(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] ws, input int hold,
                          output logic [31:0] got_rd, output logic got_err);
        int unsigned key;
        logic        err;
        int          n;
        int          lat;
        logic [31:0] merged;
        err = (a >= 32'h0000_1000);
`ifdef MEMRESP_ALIGN_CHECK_EN
        if (a[1:0] != 2'b00) err = 1'b1;
`endif
        key = {16'(d), 6'd0, a[11:2]};
        exp_err[d] = err;
        if (w || err) begin
            exp_rdata[d] = 32'h0;
            exp_known[d] = 1'b1;
        end else if (mdl.exists(key)) begin
            exp_rdata[d] = mdl[key];
            exp_known[d] = 1'b1;
        end else begin
            exp_rdata[d] = 32'h0;
            exp_known[d] = 1'b0;
        end
        n = 0;
        @(negedge clk);
        while (qready[d] !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("accept_wait", 32'(n < 50), 32'd1);
        rv[d] = 1'b1; rw[d] = w; ra[d] = a; rd[d] = wd; rs[d] = ws;
        exp_pend[d] = 1'b1;
        @(posedge clk);
        acc_time[d] = $time;
        #1 rv[d] = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (pvalid[d] !== 1'b1 && lat < 40);
        chk("latency", 32'(lat), (d == 0) ? 32'd3 : 32'd1);
        got_rd  = prdata[d];
        got_err = perr[d];
        if (w && !err) begin
            if (mdl.exists(key)) begin
                merged = mdl[key];
                for (int i = 0; i < 4; i++) if (ws[i]) merged[8*i +: 8] = wd[8*i +: 8];
                mdl[key] = merged;
            end else if (ws == 4'hF) begin
                mdl[key] = wd;
            end
        end
        // While held off, present a conflicting store that must be ignored
        if (hold > 0) begin
            rv[d] = 1'b1; rw[d] = 1'b1; ra[d] = 32'h40; rd[d] = 32'hFFFF_FFFF; rs[d] = 4'hF;
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("req_ready_held", 32'(qready[d]), 32'd0);
            chk("rsp_valid_held", 32'(pvalid[d]), 32'd1);
        end
        rv[d] = 1'b0;
        rr[d] = 1'b1;
        @(posedge clk);
        #1 rr[d] = 1'b0;
        exp_pend[d] = 1'b0;
    endtask

    task automatic chk_reset_vals(input int d);
        chk("rst_req_ready", 32'(qready[d]), 32'd1);
        chk("rst_rsp_valid", 32'(pvalid[d]), 32'd0);
        chk("rst_rsp_rdata", prdata[d], 32'h0);
        chk("rst_rsp_err", 32'(perr[d]), 32'd0);
        chk("rst_busy", 32'(pbusy[d]), 32'd0);
    endtask

    initial begin
        #100000;
        failures++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        logic [31:0] r;
        logic        e;
        time         t0;
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b0; rv[d] = 1'b0; rw[d] = 1'b0; ra[d] = 32'h0;
            rd[d] = 32'h0; rs[d] = 4'h0; rr[d] = 1'b0;
            exp_pend[d] = 1'b0; exp_err[d] = 1'b0; exp_known[d] = 1'b0; exp_rdata[d] = 32'h0;
            acc_time[d] = 0;
        end
        repeat (3) @(negedge clk);
        chk_reset_vals(0);
        chk_reset_vals(1);
        rst[0] = 1'b1;
        rst[1] = 1'b1;
        @(negedge clk);

        // Full-word store then load, back to back
        do_req(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 0, r, e);
        t0 = acc_time[0];
        chk("wr_rdata_zero", r, 32'h0);
        chk("wr_err_zero", 32'(e), 32'd0);
        do_req(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, r, e);
        chk("rd_after_wr", r, 32'hDEAD_BEEF);
        chk("throughput_l2", 32'(acc_time[0] - t0), 32'd40);

        // Byte strobes
        do_req(0, 1'b1, 32'h20, 32'h1122_3344, 4'hF, 0, r, e);
        do_req(0, 1'b1, 32'h20, 32'hAABB_CCDD, 4'h5, 0, r, e);
        do_req(0, 1'b0, 32'h20, 32'h0, 4'h0, 0, r, e);
        chk("strobe_merge", r, 32'h11BB_33DD);

        // Backpressure with an ignored competing store
        do_req(0, 1'b1, 32'h40, 32'h0102_0304, 4'hF, 0, r, e);
        do_req(0, 1'b0, 32'h40, 32'h0, 4'h3, 5, r, e);
        chk("bp_rdata", r, 32'h0102_0304);
        do_req(0, 1'b0, 32'h40, 32'h0, 4'h0, 0, r, e);
        chk("bp_no_side_store", r, 32'h0102_0304);

        // Out of range
        do_req(0, 1'b0, 32'h1000, 32'h0, 4'hF, 0, r, e);
        chk("oor_rd_err", 32'(e), 32'd1);
        chk("oor_rd_rdata", r, 32'h0);
        do_req(0, 1'b1, 32'hFFFF_FFFC, 32'h5555_5555, 4'hF, 0, r, e);
        chk("oor_wr_err", 32'(e), 32'd1);

        // Misaligned store
        do_req(0, 1'b1, 32'h22, 32'hCAFE_F00D, 4'hF, 0, r, e);
`ifdef MEMRESP_ALIGN_CHECK_EN
        chk("misalign_err", 32'(e), 32'd1);
        do_req(0, 1'b0, 32'h20, 32'h0, 4'h0, 0, r, e);
        chk("misalign_dropped", r, 32'h11BB_33DD);
`else
        chk("misalign_err", 32'(e), 32'd0);
        do_req(0, 1'b0, 32'h20, 32'h0, 4'h0, 0, r, e);
        chk("misalign_written", r, 32'hCAFE_F00D);
`endif

        // Zero-strobe store is a legal no-op
        do_req(0, 1'b1, 32'h10, 32'h0BAD_0BAD, 4'h0, 0, r, e);
        chk("wstrb0_err", 32'(e), 32'd0);
        do_req(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, r, e);
        chk("wstrb0_unchanged", r, 32'hDEAD_BEEF);

        // Reset while waiting aborts the store
        do_req(0, 1'b1, 32'h30, 32'h0BAD_F00D, 4'hF, 0, r, e);
        @(negedge clk);
        rv[0] = 1'b1; rw[0] = 1'b1; ra[0] = 32'h30; rd[0] = 32'h1234_5678; rs[0] = 4'hF;
        @(posedge clk);
        #1 rv[0] = 1'b0;
        @(negedge clk);
        chk("wait_busy", 32'(pbusy[0]), 32'd1);
        rst[0] = 1'b0;
        #1;
        chk_reset_vals(0);
        @(negedge clk);
        rst[0] = 1'b1;
        do_req(0, 1'b0, 32'h30, 32'h0, 4'h0, 0, r, e);
        chk("abort_old_value", r, 32'h0BAD_F00D);

        // Zero wait states
        do_req(1, 1'b1, 32'h4, 32'h1357_9BDF, 4'hF, 0, r, e);
        t0 = acc_time[1];
        chk("l0_wr_err", 32'(e), 32'd0);
        do_req(1, 1'b0, 32'h4, 32'h0, 4'h0, 0, r, e);
        chk("l0_rd", r, 32'h1357_9BDF);
        chk("throughput_l0", 32'(acc_time[1] - t0), 32'd20);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
